// File: rtl/axis_pkg.sv
// Shared stream definitions for the counting-packet source and its checker.
// Holds the default geometry and the packed {data, last} beat type.
package axis_pkg;

  localparam int unsigned AXIS_DATA_WIDTH  = 8;
  localparam int unsigned AXIS_PACKET_SIZE = 16;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
    logic                       last;
  } axis_beat_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with a combinational head view and an occupancy output.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset (empties the FIFO)
//   i_push/i_push_data : write strobe and entry; ignored when full
//   i_pop           : removes the head entry; ignored when empty
//   o_head          : head entry, valid while !o_empty
//   o_full/o_empty  : occupancy flags
//   o_level         : number of stored entries (0..DEPTH)
module axis_sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage carries no reset; entries are only observable through the level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/axis_packet_checker.sv
// AXI-Stream slave for the counting-packet source. Buffers accepted beats in a
// small FIFO for a local consumer and checks each accepted beat: data must equal
// its index within the packet and tlast must sit on the final beat.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tlast/s_tready : stream slave; ready only reflects occupancy
//   out_data/out_last/out_valid/out_ready : FIFO head and consumer pop handshake
//   fill_level            : FIFO occupancy
//   pkt_count             : saturating count of clean packets
//   err_data_count        : saturating count of beats with wrong data
//   err_last_count        : saturating count of early/missing tlast events
//   pkt_done, err_pulse   : one-cycle pulses the cycle after the accepting edge
module axis_packet_checker
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = AXIS_DATA_WIDTH,
  parameter int unsigned PACKET_SIZE = AXIS_PACKET_SIZE,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_WIDTH-1:0]         s_tdata,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic                          s_tlast,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic [CNT_WIDTH-1:0]          pkt_count,
  output logic [CNT_WIDTH-1:0]          err_data_count,
  output logic [CNT_WIDTH-1:0]          err_last_count,
  output logic                          pkt_done,
  output logic                          err_pulse
);

  localparam int unsigned IDXW = $clog2(PACKET_SIZE);

  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic [DATA_WIDTH:0]   w_head;

  logic [IDXW-1:0]       r_beat_idx;
  logic                  r_pkt_bad;
  logic [CNT_WIDTH-1:0]  r_pkt_count;
  logic [CNT_WIDTH-1:0]  r_err_data_count;
  logic [CNT_WIDTH-1:0]  r_err_last_count;
  logic                  r_pkt_done;
  logic                  r_err_pulse;

  logic                  w_at_end;
  logic                  w_data_err;
  logic                  w_early_last;
  logic                  w_missing_last;
  logic                  w_closing;
  logic                  w_pkt_good;

  assign s_tready  = ~w_full;
  assign out_valid = ~w_empty;
  assign w_accept  = s_tvalid & s_tready;

  axis_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_accept),
    .i_push_data ({s_tdata, s_tlast}),
    .i_pop       (out_ready),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (fill_level)
  );

  assign out_data = w_head[DATA_WIDTH:1];
  assign out_last = w_head[0];

  assign w_at_end       = (r_beat_idx == IDXW'(PACKET_SIZE - 1));
  assign w_data_err     = (s_tdata != DATA_WIDTH'(r_beat_idx));
  assign w_early_last   = s_tlast & ~w_at_end;
  assign w_missing_last = ~s_tlast & w_at_end;
  // A packet closes on any tlast or when the index wraps without one.
  assign w_closing      = s_tlast | w_at_end;
  assign w_pkt_good     = s_tlast & w_at_end & ~r_pkt_bad & ~w_data_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_beat_idx       <= '0;
      r_pkt_bad        <= 1'b0;
      r_pkt_count      <= '0;
      r_err_data_count <= '0;
      r_err_last_count <= '0;
      r_pkt_done       <= 1'b0;
      r_err_pulse      <= 1'b0;
    end else begin
      r_pkt_done  <= w_accept & s_tlast;
      r_err_pulse <= w_accept & (w_data_err | w_early_last | w_missing_last);
      if (w_accept) begin
        if (w_closing) begin
          r_beat_idx <= '0;
          r_pkt_bad  <= 1'b0;
        end else begin
          r_beat_idx <= r_beat_idx + 1'b1;
          // Framing errors only occur on closing beats, so only data errors stick here.
          r_pkt_bad  <= r_pkt_bad | w_data_err;
        end
        if (w_pkt_good && r_pkt_count != '1)
          r_pkt_count <= r_pkt_count + 1'b1;
        if (w_data_err && r_err_data_count != '1)
          r_err_data_count <= r_err_data_count + 1'b1;
        if ((w_early_last || w_missing_last) && r_err_last_count != '1)
          r_err_last_count <= r_err_last_count + 1'b1;
      end
    end
  end

  assign pkt_count      = r_pkt_count;
  assign err_data_count = r_err_data_count;
  assign err_last_count = r_err_last_count;
  assign pkt_done       = r_pkt_done;
  assign err_pulse      = r_err_pulse;

endmodule

// File: tb/tb_axis_packet_checker.sv
module tb_axis_packet_checker;
  import axis_pkg::*;

  localparam int DW = 8;
  localparam int PS = 16;
  localparam int FD = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2:0]    fill_level;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] err_data_count;
  logic [CW-1:0] err_last_count;
  logic          pkt_done;
  logic          err_pulse;

  axis_packet_checker #(
    .DATA_WIDTH  (DW),
    .PACKET_SIZE (PS),
    .FIFO_DEPTH  (FD),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .s_tdata        (s_tdata),
    .s_tvalid       (s_tvalid),
    .s_tready       (s_tready),
    .s_tlast        (s_tlast),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .fill_level     (fill_level),
    .pkt_count      (pkt_count),
    .err_data_count (err_data_count),
    .err_last_count (err_last_count),
    .pkt_done       (pkt_done),
    .err_pulse      (err_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_errp   = 0;

  // Reference model: queue of buffered beats plus packet-level bookkeeping.
  axis_beat_t q[$];
  int m_idx, m_pkt, m_ed, m_el;
  bit m_bad, m_done, m_err;

  function automatic int sat_inc(int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_idx = 0; m_pkt = 0; m_ed = 0; m_el = 0;
    m_bad = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input bit l);
    bit derr, final_beat, framing;
    derr       = (int'(d) != (m_idx % (1 << DW)));
    final_beat = (m_idx == PS - 1);
    framing    = (l != final_beat);
    if (derr)    m_ed = sat_inc(m_ed);
    if (framing) m_el = sat_inc(m_el);
    if (l && final_beat && !m_bad && !derr) m_pkt = sat_inc(m_pkt);
    m_done = l;
    m_err  = derr || framing;
    if (l || final_beat) begin
      m_idx = 0;
      m_bad = 0;
    end else begin
      m_idx = m_idx + 1;
      m_bad = m_bad || derr;
    end
  endtask

  task automatic compare_all();
    check("fill_level", fill_level, q.size());
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_data", out_data, q[0].data);
      check("out_last", out_last, q[0].last);
    end
    check("pkt_count", pkt_count, m_pkt);
    check("err_data_count", err_data_count, m_ed);
    check("err_last_count", err_last_count, m_el);
    check("pkt_done", pkt_done, m_done);
    check("err_pulse", err_pulse, m_err);
  endtask

  // One clock: drive inputs, check ready before the edge, then outputs after it.
  task automatic step(input logic [DW-1:0] d, input bit v, input bit l, input bit r,
                      output bit acc);
    bit pop;
    s_tdata = d; s_tvalid = v; s_tlast = l; out_ready = r;
    #1;
    check("s_tready", s_tready, q.size() != FD);
    acc = v && (q.size() != FD);
    pop = r && (q.size() != 0);
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    m_done = 0; m_err = 0;
    if (acc) begin
      q.push_back('{data: d, last: l});
      model_beat(d, l);
    end
    compare_all();
    if (pkt_done)  n_done++;
    if (err_pulse) n_errp++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    s_tvalid = 1'b0;
    #2;
    model_clear();
    check("rst_out_valid", out_valid, 0);
    check("rst_fill", fill_level, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_errd", err_data_count, 0);
    check("rst_errl", err_last_count, 0);
    check("rst_pulses", {pkt_done, err_pulse}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    n_done = 0; n_errp = 0;
  endtask

  task automatic send_pkt(input int n, input int errbeat, input logic [DW-1:0] errval,
                          input int lastbeat);
    bit acc;
    for (int i = 0; i < n; i++) begin
      step((i == errbeat) ? errval : DW'(i), 1'b1, i == lastbeat, 1'b1, acc);
      if (!acc) check("send_accept", 0, 1);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, 1'b1, acc);
  endtask

  typedef struct {
    logic [DW-1:0] d;
    bit v, l, r;
    bit exp_rdy;
    int exp_lvl;
  } vec_t;

  vec_t tbl[11];

  initial begin
    bit acc;
    int guard;
    logic [DW-1:0] d;
    bit l;
    tbl[0]  = '{8'd0, 1, 0, 0, 1, 1};
    tbl[1]  = '{8'd1, 1, 0, 0, 1, 2};
    tbl[2]  = '{8'd2, 1, 0, 0, 1, 3};
    tbl[3]  = '{8'd3, 1, 0, 0, 1, 4};
    tbl[4]  = '{8'd4, 1, 0, 0, 0, 4};
    tbl[5]  = '{8'd4, 1, 0, 1, 0, 3};
    tbl[6]  = '{8'd4, 1, 0, 1, 1, 3};
    tbl[7]  = '{8'd5, 1, 0, 1, 1, 3};
    tbl[8]  = '{8'd0, 0, 0, 1, 1, 2};
    tbl[9]  = '{8'd0, 0, 0, 1, 1, 1};
    tbl[10] = '{8'd0, 0, 0, 1, 1, 0};

    model_clear();
    repeat (2) @(negedge clk);
    do_reset();
    #1;
    check("ready_after_reset", s_tready, 1);

    // Clean stream: three packets.
    for (int p = 0; p < 3; p++) send_pkt(PS, -1, '0, PS - 1);
    idle(3);
    check("clean_pkt_count", pkt_count, 3);
    check("clean_errd", err_data_count, 0);
    check("clean_errl", err_last_count, 0);
    check("clean_done_pulses", n_done, 3);

    // Data error on beat 5, then a clean packet.
    do_reset();
    send_pkt(PS, 5, 8'hAA, PS - 1);
    send_pkt(PS, -1, '0, PS - 1);
    idle(2);
    check("derr_count", err_data_count, 1);
    check("derr_pulses", n_errp, 1);
    check("derr_pkt_count", pkt_count, 1);

    // Early tlast on beat 9, then a clean packet.
    do_reset();
    send_pkt(10, -1, '0, 9);
    send_pkt(PS, -1, '0, PS - 1);
    idle(2);
    check("early_errl", err_last_count, 1);
    check("early_pkt_count", pkt_count, 1);

    // Missing tlast on beat 15, next packet starts at index 0.
    do_reset();
    send_pkt(PS, -1, '0, -1);
    send_pkt(PS, -1, '0, PS - 1);
    idle(2);
    check("miss_errl", err_last_count, 1);
    check("miss_errd", err_data_count, 0);
    check("miss_pkt_count", pkt_count, 1);

    // Backpressure table.
    do_reset();
    foreach (tbl[i]) begin
      #1;
      check("tbl_tready", s_tready, tbl[i].exp_rdy);
      step(tbl[i].d, tbl[i].v, tbl[i].l, tbl[i].r, acc);
      check("tbl_level", fill_level, tbl[i].exp_lvl);
    end

    // Reset mid-packet with two beats buffered.
    do_reset();
    step(8'd0, 1'b1, 1'b0, 1'b0, acc);
    step(8'd1, 1'b1, 1'b0, 1'b0, acc);
    check("pre_reset_fill", fill_level, 2);
    do_reset();
    send_pkt(PS, -1, '0, PS - 1);
    idle(2);
    check("post_reset_pkt", pkt_count, 1);

    // Randomised traffic with gaps, consumer stalls and injected errors.
    do_reset();
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < PS; i++) begin
        d = DW'(i);
        l = (i == PS - 1);
        if ($urandom_range(19) == 0) d = DW'($urandom);
        if ($urandom_range(29) == 0) l = ~l;
        while ($urandom_range(3) == 0) step(DW'($urandom), 1'b0, 1'b0, $urandom_range(3) != 0, acc);
        guard = 0;
        do begin
          step(d, 1'b1, l, $urandom_range(3) != 0, acc);
          guard++;
        end while (!acc && guard < 100);
        if (!acc) check("random_accept_timeout", 0, 1);
      end
    end
    idle(FD + 2);
    check("random_drained", fill_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
